// File: rtl/buffer_command_unit.sv
// Board-key command front end for the associative buffer: sync, optional debounce (BUFFER_CMD_DEBOUNCE_EN), one-shot command issue.
// Latency: command one cycle after press event; no backpressure, presses during ISSUE/HOLDOFF are dropped until all keys release.
module buffer_command_unit #(
  parameter int KEY_WIDTH       = 4,
  parameter int DATA_WIDTH      = 4,
  parameter int CTRL_WIDTH      = 2,
  parameter int DEBOUNCE_CYCLES = 500_000
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  btn_clr,
  input  logic                  btn_load,
  input  logic                  btn_incr,
  input  logic                  btn_read_all,
  input  logic [KEY_WIDTH-1:0]  sw_key,
  input  logic [DATA_WIDTH-1:0] sw_data,
  output logic [CTRL_WIDTH-1:0] ctrl,
  output logic [KEY_WIDTH-1:0]  key,
  output logic [DATA_WIDTH-1:0] data_output,
  output logic                  read_all,
  output logic                  busy
);

  localparam logic [CTRL_WIDTH-1:0] CMD_NONE = CTRL_WIDTH'(0);
  localparam logic [CTRL_WIDTH-1:0] CMD_CLR  = CTRL_WIDTH'(1);
  localparam logic [CTRL_WIDTH-1:0] CMD_LOAD = CTRL_WIDTH'(2);
  localparam logic [CTRL_WIDTH-1:0] CMD_INCR = CTRL_WIDTH'(3);

  if (DEBOUNCE_CYCLES < 1) begin : g_bad_debounce
    $error("DEBOUNCE_CYCLES must be at least 1");
  end

  typedef enum logic [1:0] {IDLE, ISSUE, HOLDOFF} state_t;

  // Bit order: 0 clr, 1 load, 2 incr, 3 read_all; all keys are active-low.
  logic [3:0] btn_raw;
  logic [3:0] sync_1;
  logic [3:0] sync_2;
  logic [3:0] stable;
  logic [3:0] stable_prev;
  logic [3:0] press;

  assign btn_raw = {btn_read_all, btn_incr, btn_load, btn_clr};

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync_1      <= '1;
      sync_2      <= '1;
      stable_prev <= '1;
    end else begin
      sync_1      <= btn_raw;
      sync_2      <= sync_1;
      stable_prev <= stable;
    end
  end

`ifdef BUFFER_CMD_DEBOUNCE_EN
  localparam int CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [CNT_W-1:0] cnt [4];

  // Any bounce back to the stable level restarts the count, so the counter can never exceed CNT_LAST.
  for (genvar b = 0; b < 4; b++) begin : g_debounce
    always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
        cnt[b]    <= '0;
        stable[b] <= 1'b1;
      end else if (sync_2[b] == stable[b]) begin
        cnt[b]    <= '0;
      end else if (cnt[b] == CNT_LAST) begin
        cnt[b]    <= '0;
        stable[b] <= sync_2[b];
      end else begin
        cnt[b]    <= cnt[b] + CNT_W'(1);
      end
    end
  end
`else
  assign stable = sync_2;
`endif

  assign press = stable_prev & ~stable;

  state_t                  state;
  state_t                  state_nxt;
  logic [CTRL_WIDTH-1:0]   cmd;
  logic [CTRL_WIDTH-1:0]   cmd_nxt;
  logic                    cmd_ra;
  logic                    cmd_ra_nxt;
  logic                    capture;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= IDLE;
      cmd         <= CMD_NONE;
      cmd_ra      <= 1'b0;
      key         <= '0;
      data_output <= '0;
    end else begin
      state  <= state_nxt;
      cmd    <= cmd_nxt;
      cmd_ra <= cmd_ra_nxt;
      if (capture) begin
        key         <= sw_key;
        data_output <= sw_data;
      end
    end
  end

  always_comb begin
    state_nxt  = state;
    cmd_nxt    = cmd;
    cmd_ra_nxt = cmd_ra;
    capture    = 1'b0;
    ctrl       = CMD_NONE;
    read_all   = 1'b0;
    case (state)
      IDLE: begin
        if (|press) begin
          capture   = 1'b1;
          state_nxt = ISSUE;
          // Highest-priority event wins; the rest are discarded.
          if (press[3]) begin
            cmd_ra_nxt = 1'b1;
            cmd_nxt    = CMD_NONE;
          end else begin
            cmd_ra_nxt = 1'b0;
            if (press[0])      cmd_nxt = CMD_CLR;
            else if (press[1]) cmd_nxt = CMD_LOAD;
            else               cmd_nxt = CMD_INCR;
          end
        end
      end
      ISSUE: begin
        ctrl      = cmd;
        read_all  = cmd_ra;
        state_nxt = HOLDOFF;
      end
      HOLDOFF: begin
        if (&stable) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign busy = (state != IDLE);

endmodule

// File: tb/tb_buffer_command_unit.sv
// Directed bench for buffer_command_unit; adapts expected latency to BUFFER_CMD_DEBOUNCE_EN.
module tb_buffer_command_unit;

  localparam int KW = 4;
  localparam int DW = 4;
  localparam int CW = 2;
  localparam int DB = 4;
`ifdef BUFFER_CMD_DEBOUNCE_EN
  // 2 sync edges + 4 debounce edges to accept, +1 edge into ISSUE.
  localparam int LAT = 7;
`else
  // 2 sync edges, +1 edge into ISSUE.
  localparam int LAT = 3;
`endif

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          btn_clr = 1'b1;
  logic          btn_load = 1'b1;
  logic          btn_incr = 1'b1;
  logic          btn_read_all = 1'b1;
  logic [KW-1:0] sw_key = '0;
  logic [DW-1:0] sw_data = '0;
  logic [CW-1:0] ctrl;
  logic [KW-1:0] key;
  logic [DW-1:0] data_output;
  logic          read_all;
  logic          busy;

  buffer_command_unit #(
    .KEY_WIDTH(KW), .DATA_WIDTH(DW), .CTRL_WIDTH(CW), .DEBOUNCE_CYCLES(DB)
  ) dut (
    .clk(clk), .rst(rst),
    .btn_clr(btn_clr), .btn_load(btn_load), .btn_incr(btn_incr), .btn_read_all(btn_read_all),
    .sw_key(sw_key), .sw_data(sw_data),
    .ctrl(ctrl), .key(key), .data_output(data_output), .read_all(read_all), .busy(busy)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic step(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Observe a window of cycles: first cycle with any command, ctrl/read_all pulse counts.
  task automatic watch(input int cycles, output int first, output int hits,
                       output logic [CW-1:0] seen, output int ra_hits);
    first = -1; hits = 0; ra_hits = 0; seen = '0;
    for (int i = 1; i <= cycles; i++) begin
      step();
      if (ctrl != '0) begin
        hits++;
        seen = ctrl;
        if (first < 0) first = i;
      end
      if (read_all) begin
        ra_hits++;
        if (first < 0) first = i;
      end
    end
  endtask

  task automatic wait_idle(input string tag);
    int n;
    n = 0;
    while (busy && n < 40) begin
      step();
      n++;
    end
    check(tag, 32'(busy), 32'd0);
  endtask

  int            first;
  int            hits;
  int            ra_hits;
  logic [CW-1:0] seen;

  initial begin
    step(2);
    check("rst_ctrl", 32'(ctrl), 32'd0);
    check("rst_key", 32'(key), 32'd0);
    check("rst_data", 32'(data_output), 32'd0);
    check("rst_read_all", 32'(read_all), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    rst = 1'b1;
    step(2);

    // LOAD with hold: single pulse, latched switches, busy until release.
    sw_key = 4'd5; sw_data = 4'd9; btn_load = 1'b0;
    watch(LAT + 3, first, hits, seen, ra_hits);
    check("load_latency", 32'(first), 32'(LAT));
    check("load_hits", 32'(hits), 32'd1);
    check("load_ctrl", 32'(seen), 32'd2);
    check("load_ra", 32'(ra_hits), 32'd0);
    check("load_key", 32'(key), 32'd5);
    check("load_data", 32'(data_output), 32'd9);
    check("load_busy_held", 32'(busy), 32'd1);
    sw_key = 4'd3; sw_data = 4'd1;
    step(2);
    check("load_key_hold", 32'(key), 32'd5);
    btn_load = 1'b1;
    wait_idle("load_release_idle");
    check("load_data_hold", 32'(data_output), 32'd9);

`ifdef BUFFER_CMD_DEBOUNCE_EN
    // Short glitch must not survive the debouncer.
    btn_incr = 1'b0;
    step(2);
    btn_incr = 1'b1;
    watch(12, first, hits, seen, ra_hits);
    check("glitch_hits", 32'(hits), 32'd0);
    check("glitch_busy", 32'(busy), 32'd0);
`endif

    // read_all beats CLR when both arrive together.
    sw_key = 4'hA; sw_data = 4'h6;
    btn_read_all = 1'b0; btn_clr = 1'b0;
    watch(LAT + 3, first, hits, seen, ra_hits);
    check("ra_latency", 32'(first), 32'(LAT));
    check("ra_pulses", 32'(ra_hits), 32'd1);
    check("ra_no_ctrl", 32'(hits), 32'd0);
    check("ra_key", 32'(key), 32'hA);
    btn_read_all = 1'b1; btn_clr = 1'b1;
    wait_idle("ra_release_idle");

    // CLR held, INCR pressed during holdoff is ignored.
    btn_clr = 1'b0;
    watch(LAT + 2, first, hits, seen, ra_hits);
    check("clr_hits", 32'(hits), 32'd1);
    check("clr_ctrl", 32'(seen), 32'd1);
    btn_incr = 1'b0;
    watch(LAT + 4, first, hits, seen, ra_hits);
    check("incr_ignored", 32'(hits), 32'd0);
    check("holdoff_busy", 32'(busy), 32'd1);
    btn_clr = 1'b1; btn_incr = 1'b1;
    wait_idle("clr_release_idle");
    sw_key = 4'd7; sw_data = 4'd2;
    btn_incr = 1'b0;
    watch(LAT + 3, first, hits, seen, ra_hits);
    check("incr_hits", 32'(hits), 32'd1);
    check("incr_ctrl", 32'(seen), 32'd3);
    check("incr_key", 32'(key), 32'd7);
    btn_incr = 1'b1;
    wait_idle("incr_release_idle");

    // Reset during the ISSUE cycle of a LOAD.
    sw_key = 4'hC; sw_data = 4'hD;
    btn_load = 1'b0;
    step(LAT);
    check("pre_rst_issue", 32'(ctrl), 32'd2);
    rst = 1'b0;
    #1;
    check("rst_issue_ctrl", 32'(ctrl), 32'd0);
    check("rst_issue_key", 32'(key), 32'd0);
    check("rst_issue_data", 32'(data_output), 32'd0);
    check("rst_issue_busy", 32'(busy), 32'd0);
    btn_load = 1'b1;
    step(2);
    rst = 1'b1;
    watch(LAT + 5, first, hits, seen, ra_hits);
    check("post_rst_no_cmd", 32'(hits), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
